// File: rtl/csr_write_unit.sv
// Machine-mode CSR write/update unit: RW/RS/RC, ECALL, MRET and optional external-interrupt entry.
// Define CSR_IRQ_EN to let a pending enabled MEIP preempt requests in IDLE.
package csr_write_pkg;
    typedef struct packed {
        logic [1:0]  mode;
        logic [63:0] mstatus;
        logic [63:0] mie;
        logic [63:0] mtvec;
        logic [63:0] mscratch;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mtval;
        logic [63:0] mip;
    } csrs_t;

    localparam logic [2:0] OP_RW    = 3'd1;
    localparam logic [2:0] OP_RS    = 3'd2;
    localparam logic [2:0] OP_RC    = 3'd3;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;
endpackage

module csr_write_unit
    import csr_write_pkg::*;
#(
    parameter logic [1:0]  RESET_MODE  = 2'b11,
    parameter logic [63:0] MTVEC_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [63:0] req_pc,
    input  logic        ext_irq,
    input  logic [63:0] irq_pc,
    output logic        done_valid,
    output logic [63:0] old_data,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output csrs_t       csrGroup
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    csrs_t       csr;
    logic        lat_irq;
    logic [2:0]  lat_op;
    logic [11:0] lat_addr;
    logic [63:0] lat_wdata;
    logic [63:0] lat_pc;
    logic [63:0] rd_val;
    logic [63:0] wr_val;
    logic        irq_take;

    assign csrGroup = csr;

`ifdef CSR_IRQ_EN
    assign irq_take = (state == IDLE) && csr.mstatus[3] && csr.mie[11] && csr.mip[11];
`else
    logic unused_irq_pc;
    assign unused_irq_pc = ^irq_pc;
    assign irq_take = 1'b0;
`endif

    assign req_ready = (state == IDLE) && !irq_take;

    always_comb begin
        rd_val = '0;
        case (lat_addr)
            12'h300: rd_val = csr.mstatus;
            12'h304: rd_val = csr.mie;
            12'h305: rd_val = csr.mtvec;
            12'h340: rd_val = csr.mscratch;
            12'h341: rd_val = csr.mepc;
            12'h342: rd_val = csr.mcause;
            12'h343: rd_val = csr.mtval;
            12'h344: rd_val = csr.mip;
            default: rd_val = '0;
        endcase
        wr_val = rd_val;
        case (lat_op)
            OP_RW:   wr_val = lat_wdata;
            OP_RS:   wr_val = rd_val | lat_wdata;
            OP_RC:   wr_val = rd_val & ~lat_wdata;
            default: wr_val = rd_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            csr            <= '0;
            csr.mode       <= RESET_MODE;
            csr.mtvec      <= MTVEC_RESET;
            lat_irq        <= 1'b0;
            lat_op         <= '0;
            lat_addr       <= '0;
            lat_wdata      <= '0;
            lat_pc         <= '0;
            done_valid     <= 1'b0;
            old_data       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            // MEIP mirrors the external line every cycle; software writes to mip are dropped
            csr.mip <= {52'b0, ext_irq, 11'b0};
            case (state)
                IDLE: begin
                    if (irq_take) begin
                        lat_irq <= 1'b1;
                        lat_op  <= '0;
                        lat_pc  <= irq_pc;
                        state   <= EXEC;
                    end else if (req_valid) begin
                        lat_irq   <= 1'b0;
                        lat_op    <= req_op;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_pc    <= req_pc;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    state          <= RESP;
                    done_valid     <= 1'b1;
                    old_data       <= '0;
                    redirect_valid <= 1'b0;
                    if (lat_irq || lat_op == OP_ECALL) begin
                        csr.mepc           <= lat_pc;
                        csr.mcause         <= lat_irq ? 64'h8000_0000_0000_000B
                                                      : 64'd8 + {62'b0, csr.mode};
                        csr.mtval          <= '0;
                        csr.mstatus[7]     <= csr.mstatus[3];
                        csr.mstatus[3]     <= 1'b0;
                        csr.mstatus[12:11] <= csr.mode;
                        csr.mode           <= 2'b11;
                        redirect_valid     <= 1'b1;
                        redirect_pc        <= {csr.mtvec[63:2], 2'b00};
                    end else begin
                        case (lat_op)
                            OP_MRET: begin
                                csr.mode           <= csr.mstatus[12:11];
                                csr.mstatus[3]     <= csr.mstatus[7];
                                csr.mstatus[7]     <= 1'b1;
                                csr.mstatus[12:11] <= 2'b00;
                                redirect_valid     <= 1'b1;
                                redirect_pc        <= csr.mepc;
                            end
                            OP_RW, OP_RS, OP_RC: begin
                                old_data <= rd_val;
                                case (lat_addr)
                                    12'h300: csr.mstatus  <= wr_val;
                                    12'h304: csr.mie      <= wr_val;
                                    12'h305: csr.mtvec    <= {wr_val[63:2], 2'b00};
                                    12'h340: csr.mscratch <= wr_val;
                                    12'h341: csr.mepc     <= {wr_val[63:2], 2'b00};
                                    12'h342: csr.mcause   <= wr_val;
                                    12'h343: csr.mtval    <= wr_val;
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
                RESP: begin
                    done_valid     <= 1'b0;
                    redirect_valid <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_write_unit.sv
// Directed plus randomized checks of csr_write_unit against an address-keyed CSR model.
module tb_csr_write_unit;
    import csr_write_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] req_pc;
    logic        ext_irq;
    logic [63:0] irq_pc;
    logic        done_valid;
    logic [63:0] old_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    csrs_t       csrGroup;

    int checks = 0;
    int failures = 0;

    logic [63:0] m [int];
    logic [1:0]  m_mode;

    csr_write_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .ext_irq(ext_irq), .irq_pc(irq_pc), .done_valid(done_valid), .old_data(old_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .csrGroup(csrGroup)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_csrs(input string tag);
        chk({tag, ".mode"},     {62'b0, csrGroup.mode}, {62'b0, m_mode});
        chk({tag, ".mstatus"},  csrGroup.mstatus,  m['h300]);
        chk({tag, ".mie"},      csrGroup.mie,      m['h304]);
        chk({tag, ".mtvec"},    csrGroup.mtvec,    m['h305]);
        chk({tag, ".mscratch"}, csrGroup.mscratch, m['h340]);
        chk({tag, ".mepc"},     csrGroup.mepc,     m['h341]);
        chk({tag, ".mcause"},   csrGroup.mcause,   m['h342]);
        chk({tag, ".mtval"},    csrGroup.mtval,    m['h343]);
        chk({tag, ".mip"},      csrGroup.mip,      m['h344]);
    endtask

    function automatic void model_reset();
        int addrs[9] = '{'h300, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343, 'h344, 0};
        m.delete();
        for (int i = 0; i < 8; i++) m[addrs[i]] = 64'h0;
        m_mode = 2'b11;
    endfunction

    // Trap entry in model terms: save pc/cause, stack MIE into MPIE, record previous mode.
    function automatic logic [63:0] model_trap(input logic [63:0] pc, input logic [63:0] cause);
        logic [63:0] st = m['h300];
        m['h341] = pc;
        m['h342] = cause;
        m['h343] = 0;
        st = (st & ~64'h1888) | (st[3] ? 64'h80 : 64'h0) | (64'(m_mode) << 11);
        m['h300] = st;
        m_mode = 2'b11;
        return m['h305] & ~64'h3;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic run_op(input logic [2:0] op, input logic [11:0] addr,
                          input logic [63:0] wd, input logic [63:0] pc);
        logic [63:0] e_old = 0;
        logic [63:0] e_rpc = 0;
        logic [63:0] nv;
        logic [63:0] st;
        logic        e_redir = 0;
        bit          chk_old = 1;
        int          n = 0;
        case (op)
            3'd1, 3'd2, 3'd3: begin
                if (m.exists(int'(addr))) begin
                    e_old = m[int'(addr)];
                    nv = (op == 1) ? wd : (op == 2) ? (e_old | wd) : (e_old & ~wd);
                    if (addr == 12'h305 || addr == 12'h341) nv &= ~64'h3;
                    if (addr != 12'h344) m[int'(addr)] = nv;
                end
            end
            3'd4: begin
                e_redir = 1;
                e_rpc = model_trap(pc, (m_mode == 2'b11) ? 64'd11 : 64'd8);
            end
            3'd5: begin
                e_redir = 1;
                e_rpc = m['h341];
                st = m['h300];
                m_mode = st[12:11];
                st = (st & ~64'h1888) | (st[7] ? 64'h8 : 64'h0) | 64'h80;
                m['h300] = st;
            end
            default: chk_old = 0;
        endcase
        req_valid = 1; req_op = op; req_addr = addr; req_wdata = wd; req_pc = pc;
        while (!req_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", {63'b0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 0;
        chk("exec_no_done", {63'b0, done_valid}, 64'd0);
        @(posedge clk); #1;
        chk("resp_done", {63'b0, done_valid}, 64'd1);
        chk("resp_redirect_valid", {63'b0, redirect_valid}, {63'b0, e_redir});
        if (e_redir) chk("resp_redirect_pc", redirect_pc, e_rpc);
        if (chk_old) chk("resp_old_data", old_data, e_old);
        chk_csrs("after_op");
        @(posedge clk); #1;
        chk("done_pulse_end", {63'b0, done_valid}, 64'd0);
        chk("redirect_pulse_end", {63'b0, redirect_valid}, 64'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [11:0] raddr;
        logic [63:0] rwd;
        logic [11:0] addr_tab [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                       12'h342, 12'h343, 12'h344, 12'h7C0, 12'h001};
        logic [2:0]  op_tab [11] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3,
                                     3'd4, 3'd5, 3'd0, 3'd6, 3'd7};
        reset = 0; req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; req_pc = 0;
        ext_irq = 0; irq_pc = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_ready", {63'b0, req_ready}, 64'd1);
        chk("rst_done", {63'b0, done_valid}, 64'd0);
        chk("rst_redirect_valid", {63'b0, redirect_valid}, 64'd0);
        chk("rst_old_data", old_data, 64'd0);
        chk("rst_redirect_pc", redirect_pc, 64'd0);
        chk_csrs("rst");

        run_op(3'd1, 12'h340, 64'hDEAD, 0);
        run_op(3'd2, 12'h340, 64'h0F00, 0);
        chk("mscratch_rs", csrGroup.mscratch, 64'hDFAD);

        run_op(3'd1, 12'h305, 64'h1003, 0);
        run_op(3'd4, 12'h000, 0, 64'h80);
        chk("ecall_mtvec", csrGroup.mtvec, 64'h1000);
        chk("ecall_mcause", csrGroup.mcause, 64'd11);
        chk("ecall_mstatus", csrGroup.mstatus, 64'h1800);

        run_op(3'd2, 12'h300, 64'h8, 0);
        run_op(3'd4, 12'h000, 0, 64'h80);
        run_op(3'd5, 12'h000, 0, 0);
        chk("mret_mstatus", csrGroup.mstatus, 64'h88);

        ext_irq = 1;
        m['h344] = 64'h800;
        run_op(3'd1, 12'h344, 64'hFFFF, 0);
        chk("mip_ro", csrGroup.mip, 64'h800);
        run_op(3'd1, 12'h7C0, 64'h1234, 0);
        ext_irq = 0;
        m['h344] = 0;
        @(posedge clk); #1;

        run_op(3'd1, 12'h305, 64'h400, 0);
        run_op(3'd2, 12'h304, 64'h800, 0);
        irq_pc = 64'h200;
        ext_irq = 1;
        m['h344] = 64'h800;
        @(posedge clk); #1;
`ifdef CSR_IRQ_EN
        chk("irq_ready_low", {63'b0, req_ready}, 64'd0);
        @(posedge clk); #1;
        chk("irq_exec_no_done", {63'b0, done_valid}, 64'd0);
        ext_irq = 0;
        @(posedge clk); #1;
        m['h344] = 0;
        chk("irq_done", {63'b0, done_valid}, 64'd1);
        chk("irq_redirect_valid", {63'b0, redirect_valid}, 64'd1);
        chk("irq_redirect_pc", redirect_pc, model_trap(64'h200, 64'h8000_0000_0000_000B));
        chk("irq_old_data", old_data, 64'd0);
        chk("irq_mcause", csrGroup.mcause, 64'h8000_0000_0000_000B);
        chk_csrs("irq");
        @(posedge clk); #1;
        chk("irq_done_end", {63'b0, done_valid}, 64'd0);
`else
        for (int i = 0; i < 3; i++) begin
            chk("noirq_ready", {63'b0, req_ready}, 64'd1);
            chk("noirq_done", {63'b0, done_valid}, 64'd0);
            @(posedge clk); #1;
        end
        chk_csrs("noirq");
        ext_irq = 0;
        @(posedge clk); #1;
        m['h344] = 0;
`endif

        // Reset landing on the EXEC cycle must discard the write and the done pulse
        req_valid = 1; req_op = 3'd1; req_addr = 12'h340; req_wdata = 64'h55;
        @(posedge clk); #1;
        req_valid = 0;
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        model_reset();
        chk("rst_exec_done0", {63'b0, done_valid}, 64'd0);
        @(posedge clk); #1;
        chk("rst_exec_done1", {63'b0, done_valid}, 64'd0);
        chk("rst_exec_ready", {63'b0, req_ready}, 64'd1);
        chk_csrs("rst_exec");

        for (int k = 0; k < 40; k++) begin
            rop = op_tab[$urandom_range(0, 10)];
            raddr = addr_tab[$urandom_range(0, 9)];
            rwd = {$urandom, $urandom};
            if (raddr == 12'h300) rwd &= ~64'h1800;
            run_op(rop, raddr, rwd, {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
